// File: rtl/axi4_tracker_pkg.sv
// Shared constants and types for the passive AXI4 write-port tracker.
package axi4_tracker_pkg;

    localparam int unsigned ERR_AW_OVF       = 0;
    localparam int unsigned ERR_W_ORPHAN     = 1;
    localparam int unsigned ERR_EARLY_LAST   = 2;
    localparam int unsigned ERR_MISSING_LAST = 3;
    localparam int unsigned ERR_B_ORPHAN     = 4;
    localparam int unsigned ERR_B_RESP       = 5;
    localparam int unsigned ERR_SIZE         = 6;
    localparam int unsigned ERR_BITS         = 7;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    // Default-width AW entry; the tracker passes its own parameter-sized entry type to the FIFO.
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
    } aw_entry_t;

endpackage

// File: rtl/axi4_tracker_aw_fifo.sv
// Synchronous FIFO of accepted AW bursts; a push while full is accepted when a pop frees a slot.
module axi4_tracker_aw_fifo
    import axi4_tracker_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = aw_entry_t
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  T                           i_data,
    input  logic                       i_pop,
    output T                           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

    T                      r_mem [DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    always_comb begin
        o_full     = (r_count == CNT_BITS'(DEPTH));
        o_empty    = (r_count == '0);
        w_pop_ok   = i_pop & !o_empty;
        w_push_ok  = i_push & (!o_full | w_pop_ok);
        o_overflow = i_push & o_full & !w_pop_ok;
        o_head     = r_mem[r_rd_ptr];
        o_count    = r_count;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            r_count <= r_count + CNT_BITS'(w_push_ok) - CNT_BITS'(w_pop_ok);
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/axi4_write_tracker_rtl.sv
// Passive AXI4 write-port tracker: matches W beats to queued AW bursts, counts B responses,
// and reports completed bursts, byte/burst statistics and sticky protocol errors.
module axi4_write_tracker_rtl
    import axi4_tracker_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned SIZE_BITS = 3,
    parameter int unsigned LEN_BITS  = 8,
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned AW_DEPTH  = 4,
    parameter int unsigned CNT_BITS  = 32
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_clear,
    input  logic                             i_aw_fire,
    input  logic [ADDR_BITS-1:0]             i_aw_addr,
    input  logic [SIZE_BITS-1:0]             i_aw_size,
    input  logic [LEN_BITS-1:0]              i_aw_len,
    input  logic                             i_w_fire,
    input  logic                             i_w_last,
    input  logic                             i_b_fire,
    input  logic [1:0]                       i_b_resp,
    output logic [$clog2(2*AW_DEPTH+1)-1:0]  o_outstanding,
    output logic                             o_done_valid,
    output logic [ADDR_BITS-1:0]             o_done_addr,
    output logic [LEN_BITS:0]                o_done_beats,
    output logic [CNT_BITS-1:0]              o_bytes_written,
    output logic [CNT_BITS-1:0]              o_bursts_done,
    output logic [ERR_BITS-1:0]              o_err,
    output logic                             o_err_any
);

    localparam int unsigned LOG_BYTES = $clog2(DATA_BITS / 8);
    localparam int unsigned OUT_BITS  = $clog2(2 * AW_DEPTH + 1);
    localparam int unsigned FCNT_BITS = $clog2(AW_DEPTH + 1);
    localparam logic [SIZE_BITS-1:0] MAX_SIZE = SIZE_BITS'(LOG_BYTES);

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic [SIZE_BITS-1:0] size;
        logic [LEN_BITS-1:0]  len;
    } entry_t;

    entry_t                 w_aw_entry;
    entry_t                 w_head;
    entry_t                 w_cur;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_fifo_ovf;
    logic [FCNT_BITS-1:0]   w_fifo_count;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_bypass;
    logic                   w_beat;
    logic                   w_last_hit;
    logic                   w_end;
    logic                   w_size_big;
    logic                   w_pend_ovf;
    logic                   w_b_orphan;
    logic [SIZE_BITS-1:0]   w_shift;
    logic [CNT_BITS:0]      w_beat_bytes;
    logic [CNT_BITS:0]      w_bytes_sum;
    logic [ERR_BITS-1:0]    w_err_set;
    logic [FCNT_BITS-1:0]   w_pend_d;
    logic [LEN_BITS-1:0]    w_beat_cnt_d;
    logic [CNT_BITS-1:0]    w_bytes_d;
    logic [CNT_BITS-1:0]    w_bursts_d;
    logic [ERR_BITS-1:0]    w_err_d;

    logic [FCNT_BITS-1:0]   r_pend;
    logic [LEN_BITS-1:0]    r_beat_cnt;
    logic                   r_done_valid;
    logic [ADDR_BITS-1:0]   r_done_addr;
    logic [LEN_BITS:0]      r_done_beats;
    logic [CNT_BITS-1:0]    r_bytes;
    logic [CNT_BITS-1:0]    r_bursts;
    logic [ERR_BITS-1:0]    r_err;
    logic                   r_err_any;

    axi4_tracker_aw_fifo #(
        .DEPTH (AW_DEPTH),
        .T     (entry_t)
    ) u_aw_fifo (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_data     (w_aw_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count),
        .o_overflow (w_fifo_ovf)
    );

    // Burst matching: a beat arriving with an empty FIFO binds to the same-cycle AW.
    always_comb begin
        w_aw_entry.addr = i_aw_addr;
        w_aw_entry.size = i_aw_size;
        w_aw_entry.len  = i_aw_len;
        w_bypass   = i_w_fire & w_fifo_empty & i_aw_fire;
        w_cur      = w_bypass ? w_aw_entry : w_head;
        w_beat     = i_w_fire & (!w_fifo_empty | i_aw_fire);
        w_last_hit = (r_beat_cnt == w_cur.len);
        w_end      = w_beat & (i_w_last | w_last_hit);
        // A bypassed burst that ends on its first beat never needs a FIFO slot.
        w_push     = i_aw_fire & !(w_bypass & w_end);
        w_pop      = w_end & !w_bypass;
        w_size_big = (w_cur.size > MAX_SIZE);
        w_shift    = w_size_big ? MAX_SIZE : w_cur.size;
        w_beat_bytes = (CNT_BITS + 1)'(1) << w_shift;
        w_bytes_sum  = {1'b0, r_bytes} + w_beat_bytes;

        w_beat_cnt_d = r_beat_cnt;
        if (w_end)       w_beat_cnt_d = '0;
        else if (w_beat) w_beat_cnt_d = r_beat_cnt + LEN_BITS'(1);
    end

    // Response bookkeeping: burst end and B in the same cycle cancel out.
    always_comb begin
        w_pend_d   = r_pend;
        w_pend_ovf = 1'b0;
        w_b_orphan = 1'b0;
        if (w_end && !i_b_fire) begin
            if (r_pend == FCNT_BITS'(AW_DEPTH)) w_pend_ovf = 1'b1;
            else                                w_pend_d   = r_pend + FCNT_BITS'(1);
        end else if (!w_end && i_b_fire) begin
            if (r_pend == '0) w_b_orphan = 1'b1;
            else              w_pend_d   = r_pend - FCNT_BITS'(1);
        end
    end

    always_comb begin
        w_err_set                   = '0;
        w_err_set[ERR_AW_OVF]       = (i_aw_fire & w_fifo_ovf) | w_pend_ovf;
        w_err_set[ERR_W_ORPHAN]     = i_w_fire & w_fifo_empty & !i_aw_fire;
        w_err_set[ERR_EARLY_LAST]   = w_beat & i_w_last & (r_beat_cnt < w_cur.len);
        w_err_set[ERR_MISSING_LAST] = w_beat & w_last_hit & !i_w_last;
        w_err_set[ERR_B_ORPHAN]     = w_b_orphan;
        w_err_set[ERR_B_RESP]       = i_b_fire & (i_b_resp != OKAY);
        w_err_set[ERR_SIZE]         = w_beat & w_size_big;

        // Clear wins over same-cycle statistics, but errors raised this cycle survive it.
        w_err_d    = (i_clear ? '0 : r_err) | w_err_set;
        w_bytes_d  = r_bytes;
        w_bursts_d = r_bursts;
        if (i_clear) begin
            w_bytes_d  = '0;
            w_bursts_d = '0;
        end else begin
            if (w_beat) w_bytes_d = w_bytes_sum[CNT_BITS] ? '1 : w_bytes_sum[CNT_BITS-1:0];
            if (w_end && r_bursts != '1) w_bursts_d = r_bursts + CNT_BITS'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pend       <= '0;
            r_beat_cnt   <= '0;
            r_done_valid <= 1'b0;
            r_done_addr  <= '0;
            r_done_beats <= '0;
            r_bytes      <= '0;
            r_bursts     <= '0;
            r_err        <= '0;
            r_err_any    <= 1'b0;
        end else begin
            r_pend       <= w_pend_d;
            r_beat_cnt   <= w_beat_cnt_d;
            r_done_valid <= w_end;
            if (w_end) begin
                r_done_addr  <= w_cur.addr;
                r_done_beats <= {1'b0, r_beat_cnt} + (LEN_BITS + 1)'(1);
            end
            r_bytes      <= w_bytes_d;
            r_bursts     <= w_bursts_d;
            r_err        <= w_err_d;
            r_err_any    <= |w_err_d;
        end
    end

    assign o_outstanding   = OUT_BITS'(w_fifo_count) + OUT_BITS'(r_pend);
    assign o_done_valid    = r_done_valid;
    assign o_done_addr     = r_done_addr;
    assign o_done_beats    = r_done_beats;
    assign o_bytes_written = r_bytes;
    assign o_bursts_done   = r_bursts;
    assign o_err           = r_err;
    assign o_err_any       = r_err_any;

endmodule

// File: tb/tb_axi4_write_tracker_rtl.sv
// Directed bench for the AXI4 write tracker; a second CNT_BITS=8 instance checks saturation.
module tb_axi4_write_tracker_rtl;

    logic        clk = 1'b0;
    logic        reset, clear, aw_fire, w_fire, w_last, b_fire;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [7:0]  aw_len;
    logic [1:0]  b_resp;

    logic [3:0]  outstanding, outstanding8;
    logic        done_valid, done_valid8, err_any, err_any8;
    logic [31:0] done_addr, done_addr8, bytes, bursts;
    logic [8:0]  done_beats, done_beats8;
    logic [7:0]  bytes8, bursts8;
    logic [6:0]  err, err8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axi4_write_tracker_rtl u_dut (
        .i_clock(clk), .i_reset(reset), .i_clear(clear), .i_aw_fire(aw_fire),
        .i_aw_addr(aw_addr), .i_aw_size(aw_size), .i_aw_len(aw_len), .i_w_fire(w_fire),
        .i_w_last(w_last), .i_b_fire(b_fire), .i_b_resp(b_resp), .o_outstanding(outstanding),
        .o_done_valid(done_valid), .o_done_addr(done_addr), .o_done_beats(done_beats),
        .o_bytes_written(bytes), .o_bursts_done(bursts), .o_err(err), .o_err_any(err_any)
    );

    axi4_write_tracker_rtl #(.CNT_BITS(8)) u_dut8 (
        .i_clock(clk), .i_reset(reset), .i_clear(clear), .i_aw_fire(aw_fire),
        .i_aw_addr(aw_addr), .i_aw_size(aw_size), .i_aw_len(aw_len), .i_w_fire(w_fire),
        .i_w_last(w_last), .i_b_fire(b_fire), .i_b_resp(b_resp), .o_outstanding(outstanding8),
        .o_done_valid(done_valid8), .o_done_addr(done_addr8), .o_done_beats(done_beats8),
        .o_bytes_written(bytes8), .o_bursts_done(bursts8), .o_err(err8), .o_err_any(err_any8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear = 0; aw_fire = 0; w_fire = 0; w_last = 0; b_fire = 0; b_resp = 2'b00;
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [2:0] s, input logic [7:0] l);
        aw_fire = 1; aw_addr = a; aw_size = s; aw_len = l;
        tick(); idle();
    endtask

    task automatic do_w(input logic l);
        w_fire = 1; w_last = l;
        tick(); idle();
    endtask

    task automatic do_b(input logic [1:0] r);
        b_fire = 1; b_resp = r;
        tick(); idle();
    endtask

    task automatic do_clear();
        clear = 1;
        tick(); idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); aw_addr = 0; aw_size = 0; aw_len = 0;
        tick(); tick();
        reset = 0;
        tick();
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outst act=%0d exp=0", outstanding); end
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL rst_done act=%0b exp=0", done_valid); end
        checks++; if (bytes !== 32'd0) begin errors++; $display("FAIL rst_bytes act=%0d exp=0", bytes); end
        checks++; if (bursts !== 32'd0) begin errors++; $display("FAIL rst_bursts act=%0d exp=0", bursts); end
        checks++; if (err !== 7'h00 || err_any !== 1'b0) begin errors++; $display("FAIL rst_err act=%h/%b exp=00/0", err, err_any); end
    endtask

    task automatic test_basic();
        do_clear();
        do_aw(32'h1000, 3'd3, 8'd3);
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL basic_outst_aw act=%0d exp=1", outstanding); end
        for (int i = 0; i < 3; i++) do_w(1'b0);
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL basic_early_done act=%0b exp=0", done_valid); end
        do_w(1'b1);
        checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL basic_done act=%0b exp=1", done_valid); end
        checks++; if (done_addr !== 32'h1000) begin errors++; $display("FAIL basic_addr act=%h exp=1000", done_addr); end
        checks++; if (done_beats !== 9'd4) begin errors++; $display("FAIL basic_beats act=%0d exp=4", done_beats); end
        checks++; if (bytes !== 32'd32) begin errors++; $display("FAIL basic_bytes act=%0d exp=32", bytes); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL basic_outst_w act=%0d exp=1", outstanding); end
        tick();
        checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse act=%0b exp=0", done_valid); end
        do_b(2'b00);
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL basic_outst_b act=%0d exp=0", outstanding); end
        checks++; if (err !== 7'h00 || bursts !== 32'd1) begin errors++; $display("FAIL basic_err act=%h/%0d exp=00/1", err, bursts); end
    endtask

    task automatic test_bypass();
        do_clear();
        aw_fire = 1; aw_addr = 32'h2000; aw_size = 3'd3; aw_len = 8'd0; w_fire = 1; w_last = 1;
        tick(); idle();
        checks++; if (done_valid !== 1'b1 || done_beats !== 9'd1) begin errors++; $display("FAIL byp_done act=%0b/%0d exp=1/1", done_valid, done_beats); end
        checks++; if (bytes !== 32'd8) begin errors++; $display("FAIL byp_bytes act=%0d exp=8", bytes); end
        checks++; if (err !== 7'h00) begin errors++; $display("FAIL byp_err act=%h exp=00", err); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL byp_outst act=%0d exp=1", outstanding); end
        aw_fire = 1; aw_addr = 32'h2100; aw_len = 8'd1; w_fire = 1; w_last = 0;
        tick(); idle();
        do_w(1'b1);
        checks++; if (done_addr !== 32'h2100 || done_beats !== 9'd2) begin errors++; $display("FAIL byp2_done act=%h/%0d exp=2100/2", done_addr, done_beats); end
        do_b(2'b00); do_b(2'b00);
        checks++; if (outstanding !== 4'd0 || err !== 7'h00) begin errors++; $display("FAIL byp_drain act=%0d/%h exp=0/00", outstanding, err); end
    endtask

    task automatic test_last_errors();
        do_clear();
        do_aw(32'h3000, 3'd3, 8'd3);
        do_w(1'b0); do_w(1'b1);
        checks++; if (err !== 7'h04) begin errors++; $display("FAIL early_err act=%h exp=04", err); end
        checks++; if (done_valid !== 1'b1 || done_beats !== 9'd2) begin errors++; $display("FAIL early_beats act=%0b/%0d exp=1/2", done_valid, done_beats); end
        do_b(2'b00);
        do_clear();
        do_aw(32'h4000, 3'd2, 8'd1);
        do_w(1'b0); do_w(1'b1);
        checks++; if (done_addr !== 32'h4000 || done_beats !== 9'd2) begin errors++; $display("FAIL next_done act=%h/%0d exp=4000/2", done_addr, done_beats); end
        checks++; if (bytes !== 32'd8 || err !== 7'h00) begin errors++; $display("FAIL next_stats act=%0d/%h exp=8/00", bytes, err); end
        do_b(2'b00);
        do_aw(32'h4100, 3'd3, 8'd1);
        do_w(1'b0); do_w(1'b0);
        checks++; if (err !== 7'h08 || done_beats !== 9'd2) begin errors++; $display("FAIL missing_last act=%h/%0d exp=08/2", err, done_beats); end
        do_b(2'b00);
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 5; i++) do_aw(32'h5000 + 32'(i) * 32'h100, 3'd3, 8'd0);
        checks++; if (err !== 7'h01) begin errors++; $display("FAIL ovf_err act=%h exp=01", err); end
        checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL ovf_outst act=%0d exp=4", outstanding); end
        for (int i = 0; i < 4; i++) do_w(1'b1);
        checks++; if (bursts !== 32'd4) begin errors++; $display("FAIL ovf_bursts act=%0d exp=4", bursts); end
        checks++; if (done_addr !== 32'h5300 || outstanding !== 4'd4) begin errors++; $display("FAIL ovf_tail act=%h/%0d exp=5300/4", done_addr, outstanding); end
        for (int i = 0; i < 4; i++) do_b(2'b00);
        checks++; if (outstanding !== 4'd0 || err !== 7'h01) begin errors++; $display("FAIL ovf_drain act=%0d/%h exp=0/01", outstanding, err); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_aw(32'h6000, 3'd3, 8'd0);
        do_w(1'b1);
        do_aw(32'h6100, 3'd3, 8'd0);
        w_fire = 1; w_last = 1; b_fire = 1;
        tick(); idle();
        checks++; if (outstanding !== 4'd1 || err !== 7'h00) begin errors++; $display("FAIL b2b_net act=%0d/%h exp=1/00", outstanding, err); end
        checks++; if (done_addr !== 32'h6100 || bursts !== 32'd2) begin errors++; $display("FAIL b2b_done act=%h/%0d exp=6100/2", done_addr, bursts); end
        do_b(2'b00);
    endtask

    task automatic test_orphans_clear();
        do_clear();
        do_b(2'b00);
        checks++; if (err !== 7'h10 || outstanding !== 4'd0) begin errors++; $display("FAIL b_orphan act=%h/%0d exp=10/0", err, outstanding); end
        do_w(1'b1);
        checks++; if (err !== 7'h12 || bytes !== 32'd0) begin errors++; $display("FAIL w_orphan act=%h/%0d exp=12/0", err, bytes); end
        do_aw(32'h7000, 3'd3, 8'd0);
        do_w(1'b1);
        do_b(2'b10);
        checks++; if (err !== 7'h32 || err_any !== 1'b1) begin errors++; $display("FAIL b_resp act=%h/%b exp=32/1", err, err_any); end
        clear = 1; b_fire = 1;
        tick(); idle();
        checks++; if (err !== 7'h10) begin errors++; $display("FAIL clear_keep act=%h exp=10", err); end
        do_clear();
        checks++; if (err !== 7'h00 || err_any !== 1'b0) begin errors++; $display("FAIL clear_err act=%h/%b exp=00/0", err, err_any); end
        checks++; if (bytes !== 32'd0 || bursts !== 32'd0) begin errors++; $display("FAIL clear_cnt act=%0d/%0d exp=0/0", bytes, bursts); end
    endtask

    task automatic test_size();
        do_clear();
        do_aw(32'h8000, 3'd4, 8'd0);
        do_w(1'b1);
        checks++; if (err !== 7'h40 || bytes !== 32'd8) begin errors++; $display("FAIL size_big act=%h/%0d exp=40/8", err, bytes); end
        do_b(2'b00);
    endtask

    task automatic test_saturation();
        do_clear();
        do_aw(32'h9000, 3'd3, 8'd31);
        for (int i = 0; i < 31; i++) do_w(1'b0);
        do_w(1'b1);
        checks++; if (bytes8 !== 8'hFF) begin errors++; $display("FAIL sat_bytes8 act=%h exp=ff", bytes8); end
        checks++; if (bytes !== 32'd256 || done_beats !== 9'd32) begin errors++; $display("FAIL sat_bytes32 act=%0d/%0d exp=256/32", bytes, done_beats); end
        do_aw(32'h9100, 3'd3, 8'd0);
        do_w(1'b1);
        checks++; if (bytes8 !== 8'hFF || bursts8 !== 8'd2) begin errors++; $display("FAIL sat_hold act=%h/%0d exp=ff/2", bytes8, bursts8); end
        do_b(2'b00); do_b(2'b00);
    endtask

    task automatic test_reset_mid();
        do_clear();
        do_aw(32'hA000, 3'd3, 8'd3);
        do_w(1'b0);
        reset = 1; tick(); reset = 0;
        checks++; if (outstanding !== 4'd0 || err !== 7'h00) begin errors++; $display("FAIL midrst act=%0d/%h exp=0/00", outstanding, err); end
        do_w(1'b1);
        checks++; if (err !== 7'h02 || bytes !== 32'd0 || done_valid !== 1'b0) begin errors++; $display("FAIL midrst_orphan act=%h/%0d/%b exp=02/0/0", err, bytes, done_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_last_errors();
        test_overflow();
        test_back_to_back();
        test_orphans_clear();
        test_size();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
